// File: rtl/ld_backend_block_seq.sv
// Load back-end block sequencer: walks a loaded token stream through the
// MyID word, NUM_IDS ID words, an attribute word, a block body of programmable
// length and an optional R-config tail. Words advance only when accepted
// (I_Valid & I_Ready). Counts completed blocks per load and flags a zero-length
// bypass entry.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   INIT   | idle, waiting for I_Event_Load
//   MYID   | expecting the MyID word
//   ID     | expecting NUM_IDS ID words (idcnt tracks position)
//   ATTRIB | expecting the attribute word; samples term/AGU/routing flags
//   BLOCK  | block body, len counts remaining words down to 1
//   TAIL   | R-config tail after a terminal block
module ld_backend_block_seq #(
    parameter int LEN_W      = 8,
    parameter int NUM_IDS    = 3,
    parameter int CNT_W      = 4,
    parameter int MAX_BLOCKS = 16,
    parameter bit EXTERNAL   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_Event_Load,
    input  logic             I_Indirect,
    input  logic             I_Valid,
    input  logic             I_Ready,
    input  logic             is_Bypass,
    input  logic             is_Term,
    input  logic             is_RoutingData,
    input  logic             is_End_Rename,
    input  logic             I_Term_AddrGen,
    input  logic             I_Set_RConfig,
    input  logic [LEN_W-1:0] I_Length,
    output logic             O_is_MyID,
    output logic             O_is_IDWord,
    output logic             O_is_AttributeWord,
    output logic             O_is_BlockWord,
    output logic             O_is_End_Block,
    output logic             O_is_End_Term_Block,
    output logic [CNT_W-1:0] O_Block_Count,
    output logic             O_Busy,
    output logic             O_Error
);

    typedef enum logic [2:0] {
        S_INIT,
        S_MYID,
        S_ID,
        S_ATTRIB,
        S_BLOCK,
        S_TAIL
    } state_t;

    localparam logic [LEN_W:0]   LEN_ONE   = (LEN_W+1)'(1);
    localparam logic [LEN_W:0]   LEN_ZERO  = '0;
    localparam logic [CNT_W-1:0] BLK_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   BLK_LIMIT = (CNT_W+1)'(MAX_BLOCKS);
    localparam logic [2:0]       ID_LAST   = 3'(NUM_IDS - 1);

    state_t           state, state_nx;
    logic [LEN_W:0]   len, len_nx;
    logic [2:0]       idcnt, idcnt_nx;
    logic [CNT_W-1:0] blk, blk_nx;
    logic             term, term_nx;
    logic             agu, agu_nx;
    logic             end_blk, end_blk_nx;
    logic             err, err_nx;

    logic             accept;
    logic [LEN_W:0]   len_full;
    logic [LEN_W:0]   len_byp;
    logic [CNT_W:0]   blk_inc;
    logic [CNT_W-1:0] blk_sat;
    logic             max_hit;

    // Length is one bit wider than I_Length so the all-ones length plus one
    // still fits; block count saturates rather than wrapping.
    assign accept   = I_Valid & I_Ready;
    assign len_full = {1'b0, I_Length} + LEN_ONE;
    assign len_byp  = I_Indirect ? {1'b0, I_Length} : len_full;
    assign blk_inc  = {1'b0, blk} + (CNT_W+1)'(1);
    assign blk_sat  = (&blk) ? blk : blk + BLK_ONE;
    assign max_hit  = (blk_inc == BLK_LIMIT);

    // State register and all sequencing counters/flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_INIT;
            len     <= '0;
            idcnt   <= '0;
            blk     <= '0;
            term    <= 1'b0;
            agu     <= 1'b0;
            end_blk <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            len     <= len_nx;
            idcnt   <= idcnt_nx;
            blk     <= blk_nx;
            term    <= term_nx;
            agu     <= agu_nx;
            end_blk <= end_blk_nx;
            err     <= err_nx;
        end
    end

    // Next-state and next-counter logic; pulses default low every cycle.
    always_comb begin
        state_nx   = state;
        len_nx     = len;
        idcnt_nx   = idcnt;
        blk_nx     = blk;
        term_nx    = term;
        agu_nx     = agu;
        end_blk_nx = 1'b0;
        err_nx     = 1'b0;
        case (state)
            S_INIT: begin
                if (I_Event_Load) begin
                    if (!is_Bypass) begin
                        state_nx = S_MYID;
                        len_nx   = len_full;
                        idcnt_nx = '0;
                        blk_nx   = '0;
                        term_nx  = 1'b0;
                        agu_nx   = 1'b0;
                    end else if (len_byp != LEN_ZERO) begin
                        state_nx = S_BLOCK;
                        len_nx   = len_byp;
                        blk_nx   = '0;
                        term_nx  = is_Term;
                        agu_nx   = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_MYID: begin
                if (I_Term_AddrGen) begin
                    state_nx = S_INIT;
                end else if (accept) begin
                    state_nx = S_ID;
                    idcnt_nx = '0;
                end
            end
            S_ID: begin
                if (accept) begin
                    if (idcnt == ID_LAST) begin
                        state_nx = S_ATTRIB;
                        idcnt_nx = '0;
                    end else begin
                        idcnt_nx = idcnt + 3'd1;
                    end
                end
            end
            S_ATTRIB: begin
                if (accept) begin
                    state_nx = S_BLOCK;
                    term_nx  = is_Term;
                    agu_nx   = I_Term_AddrGen;
                    len_nx   = is_RoutingData ? LEN_ONE : len;
                end else if (I_Term_AddrGen) begin
                    state_nx = S_INIT;
                end
            end
            S_BLOCK: begin
                agu_nx = agu | I_Term_AddrGen;
                if (is_End_Rename) begin
                    state_nx = S_INIT;
                    len_nx   = '0;
                    idcnt_nx = '0;
                    blk_nx   = '0;
                    term_nx  = 1'b0;
                    agu_nx   = 1'b0;
                end else if (accept && (len == LEN_ONE)) begin
                    blk_nx     = blk_sat;
                    end_blk_nx = 1'b1;
                    if (term && I_Set_RConfig) begin
                        state_nx = S_TAIL;
                        len_nx   = is_RoutingData ? LEN_ONE : len_full;
                    end else if (is_Bypass || agu || I_Term_AddrGen || max_hit || !EXTERNAL) begin
                        state_nx = S_INIT;
                        len_nx   = '0;
                    end else begin
                        state_nx = S_ATTRIB;
                        len_nx   = len_full;
                    end
                end else if (accept && (len != LEN_ZERO)) begin
                    len_nx = len - LEN_ONE;
                end
            end
            S_TAIL: begin
                if (accept) begin
                    if (len == LEN_ONE) begin
                        // Chaining back to MYID reloads the length for the next header.
                        state_nx = EXTERNAL ? S_MYID : S_INIT;
                        len_nx   = EXTERNAL ? len_full : LEN_ZERO;
                    end else if (len != LEN_ZERO) begin
                        len_nx = len - LEN_ONE;
                    end
                end else if (I_Term_AddrGen && !term) begin
                    state_nx = S_INIT;
                end
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // Word-class decodes straight from the state register.
    always_comb begin
        O_is_MyID           = (state == S_MYID);
        O_is_IDWord         = (state == S_ID);
        O_is_AttributeWord  = (state == S_ATTRIB);
        O_is_BlockWord      = (state == S_BLOCK) || (state == S_TAIL);
        O_is_End_Term_Block = (state == S_BLOCK) && (len == LEN_ONE) && term;
        O_Busy              = (state != S_INIT);
        O_is_End_Block      = end_blk;
        O_Error             = err;
        O_Block_Count       = blk;
    end

endmodule

// File: tb/tb_ld_backend_block_seq.sv
// Scoreboard bench for ld_backend_block_seq. Expected word classes are queued
// as each load is driven and checked against the DUT's class flags on every
// accepted word; expected block counts are queued per block and checked when
// the End_Block pulse appears.
module tb_ld_backend_block_seq;

    localparam int LEN_W = 8;
    localparam int CNT_W = 4;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_MYID = 4'b1000;
    localparam logic [3:0] C_ID   = 4'b0100;
    localparam logic [3:0] C_ATTR = 4'b0010;
    localparam logic [3:0] C_BODY = 4'b0001;

    logic             clock;
    logic             reset;
    logic             I_Event_Load, I_Indirect, I_Valid, I_Ready;
    logic             is_Bypass, is_Term, is_RoutingData, is_End_Rename;
    logic             I_Term_AddrGen, I_Set_RConfig;
    logic [LEN_W-1:0] I_Length;
    logic             O_is_MyID, O_is_IDWord, O_is_AttributeWord, O_is_BlockWord;
    logic             O_is_End_Block, O_is_End_Term_Block, O_Busy, O_Error;
    logic [CNT_W-1:0] O_Block_Count;

    logic [3:0]       word_cls;
    logic [3:0]       exp_q[$];
    int               eb_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    ld_backend_block_seq #(
        .LEN_W(LEN_W), .NUM_IDS(3), .CNT_W(CNT_W), .MAX_BLOCKS(2), .EXTERNAL(1'b1)
    ) dut (
        .clock(clock), .reset(reset),
        .I_Event_Load(I_Event_Load), .I_Indirect(I_Indirect),
        .I_Valid(I_Valid), .I_Ready(I_Ready),
        .is_Bypass(is_Bypass), .is_Term(is_Term), .is_RoutingData(is_RoutingData),
        .is_End_Rename(is_End_Rename), .I_Term_AddrGen(I_Term_AddrGen),
        .I_Set_RConfig(I_Set_RConfig), .I_Length(I_Length),
        .O_is_MyID(O_is_MyID), .O_is_IDWord(O_is_IDWord),
        .O_is_AttributeWord(O_is_AttributeWord), .O_is_BlockWord(O_is_BlockWord),
        .O_is_End_Block(O_is_End_Block), .O_is_End_Term_Block(O_is_End_Term_Block),
        .O_Block_Count(O_Block_Count), .O_Busy(O_Busy), .O_Error(O_Error)
    );

    assign word_cls = {O_is_MyID, O_is_IDWord, O_is_AttributeWord, O_is_BlockWord};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one word at the current negedge; on accept, pop and compare its class.
    task automatic send(input logic rdy);
        logic [3:0] e;
        I_Valid = 1'b1;
        I_Ready = rdy;
        if (rdy) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("word_class", word_cls, e);
            end
        end
        @(negedge clock);
        I_Valid = 1'b0;
        I_Ready = 1'b0;
    endtask

    task automatic push_header();
        exp_q.push_back(C_MYID);
        repeat (3) exp_q.push_back(C_ID);
        exp_q.push_back(C_ATTR);
    endtask

    task automatic start_load(input logic [LEN_W-1:0] len);
        I_Event_Load = 1'b1;
        I_Length     = len;
        @(negedge clock);
        I_Event_Load = 1'b0;
    endtask

    // End_Block pulses are matched against the expected per-load block count.
    always @(negedge clock) begin
        if (reset && O_is_End_Block) begin
            if (eb_q.size() == 0) check("end_block_unexpected", O_is_End_Block, 0);
            else check("end_block_count", O_Block_Count, eb_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        I_Event_Load = 0; I_Indirect = 0; I_Valid = 0; I_Ready = 0;
        is_Bypass = 0; is_Term = 0; is_RoutingData = 0; is_End_Rename = 0;
        I_Term_AddrGen = 0; I_Set_RConfig = 0; I_Length = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", O_Busy, 0);
        check("rst_cls", word_cls, C_NONE);
        check("rst_count", O_Block_Count, 0);
        check("rst_endblk", O_is_End_Block, 0);
        check("rst_err", O_Error, 0);
        check("rst_endterm", O_is_End_Term_Block, 0);
        reset = 1'b1;
        @(negedge clock);

        // Normal load, length 3 -> 4 body words, chains to ATTRIB.
        start_load(8'd3);
        check("t1_busy", O_Busy, 1);
        push_header();
        repeat (5) send(1'b1);
        repeat (4) exp_q.push_back(C_BODY);
        eb_q.push_back(1);
        repeat (4) send(1'b1);
        check("t1_endblk", O_is_End_Block, 1);
        check("t1_chain_attr", word_cls, C_ATTR);
        check("t1_count", O_Block_Count, 1);
        @(negedge clock);
        check("t1_endblk_width", O_is_End_Block, 0);

        // Second chained block under back-pressure; reaches MAX_BLOCKS=2.
        exp_q.push_back(C_ATTR);
        send(1'b1);
        repeat (4) exp_q.push_back(C_BODY);
        eb_q.push_back(2);
        for (int i = 0; i < 8; i++) begin
            if (i[0] == 1'b0) begin
                check("t2_hold_cls", word_cls, C_BODY);
                check("t2_no_early_end", O_is_End_Block, 0);
            end
            send(i[0]);
        end
        check("t2_endblk", O_is_End_Block, 1);
        check("t2_count", O_Block_Count, 2);
        check("t2_max_init", O_Busy, 0);

        // Bypass + indirect: zero length errors, length 2 runs 2 body words.
        is_Bypass = 1'b1; I_Indirect = 1'b1;
        start_load(8'd0);
        check("t3_err", O_Error, 1);
        check("t3_err_idle", O_Busy, 0);
        @(negedge clock);
        check("t3_err_pulse", O_Error, 0);
        start_load(8'd2);
        check("t3_byp_cls", word_cls, C_BODY);
        repeat (2) exp_q.push_back(C_BODY);
        eb_q.push_back(1);
        repeat (2) send(1'b1);
        check("t3_done", O_Busy, 0);
        is_Bypass = 1'b0; I_Indirect = 1'b0;

        // Terminal block with R-config tail (routing data forces tail length 1).
        is_Term = 1'b1; I_Set_RConfig = 1'b1;
        start_load(8'd1);
        push_header();
        repeat (5) send(1'b1);
        check("t4_endterm_lo", O_is_End_Term_Block, 0);
        exp_q.push_back(C_BODY);
        send(1'b1);
        check("t4_endterm_hi", O_is_End_Term_Block, 1);
        is_RoutingData = 1'b1;
        exp_q.push_back(C_BODY);
        eb_q.push_back(1);
        send(1'b1);
        check("t4_tail_cls", word_cls, C_BODY);
        check("t4_tail_endterm", O_is_End_Term_Block, 0);
        exp_q.push_back(C_BODY);
        send(1'b1);
        check("t4_myid", word_cls, C_MYID);
        is_Term = 1'b0; I_Set_RConfig = 1'b0; is_RoutingData = 1'b0;

        // AGU termination in MYID wins over a simultaneous accept.
        I_Term_AddrGen = 1'b1; I_Valid = 1'b1; I_Ready = 1'b1;
        @(negedge clock);
        I_Term_AddrGen = 1'b0; I_Valid = 1'b0; I_Ready = 1'b0;
        check("myid_agu_init", O_Busy, 0);

        // Rename abort mid-BLOCK.
        start_load(8'd5);
        push_header();
        repeat (5) send(1'b1);
        repeat (2) exp_q.push_back(C_BODY);
        repeat (2) send(1'b1);
        is_End_Rename = 1'b1;
        @(negedge clock);
        is_End_Rename = 1'b0;
        check("t6_abort_busy", O_Busy, 0);
        check("t6_abort_cls", word_cls, C_NONE);
        check("t6_abort_count", O_Block_Count, 0);
        check("t6_abort_endblk", O_is_End_Block, 0);

        // Asynchronous reset mid-ID, then a fresh load restarts cleanly.
        start_load(8'd0);
        exp_q.push_back(C_MYID);
        exp_q.push_back(C_ID);
        repeat (2) send(1'b1);
        check("t6_in_id", word_cls, C_ID);
        #3 reset = 1'b0;
        #1;
        check("t6_async_busy", O_Busy, 0);
        check("t6_async_cls", word_cls, C_NONE);
        @(negedge clock);
        reset = 1'b1;
        start_load(8'd0);
        push_header();
        repeat (5) send(1'b1);
        exp_q.push_back(C_BODY);
        eb_q.push_back(1);
        send(1'b1);
        check("t6_restart_cls", word_cls, C_ATTR);
        check("t6_restart_count", O_Block_Count, 1);
        @(negedge clock);

        check("sb_empty", exp_q.size(), 0);
        check("eb_empty", eb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
